// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART register bus initiator.
package uart_bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [9:0] REG_TR   = 10'h000;
  localparam logic [9:0] REG_CTRL = 10'h001;
  localparam logic [9:0] REG_BAUD = 10'h002;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int WDOG_W          = 10;
endpackage

// File: rtl/uart_bus_wdog.sv
// Access-phase watchdog: counts not-ready cycles and flags the cycle whose count reaches TIMEOUT.
// expired is combinational on en so the abort happens in that same cycle.
module uart_bus_wdog
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + WDOG_W'(1);
  end

  // This cycle's increment is the one that makes the count equal TIMEOUT.
  assign expired = en && (({1'b0, cnt} + (WDOG_W+1)'(1)) == (WDOG_W+1)'(TIMEOUT));
endmodule

// File: rtl/uart_bus_master.sv
// Single-outstanding setup/access bus initiator; command-to-response 3 cycles minimum.
// Response held until rsp_ready; req_ready only in IDLE; all outputs registered.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          sel,
  output logic          enable,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  input  logic [31:0]   rdata,
  input  logic          ready
);
  state_t        state_q, state_d;
  logic          req_ready_d, sel_d, enable_d, write_d, rsp_valid_d, rsp_err_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   wdata_d, rsp_rdata_d;
  logic          busy_d;
  logic          wd_clr, wd_en, wd_expired;

  assign wd_clr = (state_q == SETUP);
  assign wd_en  = (state_q == ACCESS) && !ready;

  uart_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE:   if (req_valid && req_ready) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // ready takes priority over a watchdog expiry in the same cycle
        if (ready) begin
          state_d     = RESP;
          rsp_rdata_d = write ? 32'h0 : rdata;
          rsp_err_d   = 1'b0;
        end else if (wd_expired) begin
          state_d     = RESP;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == SETUP) || (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    sel_d       = busy_d;
    enable_d    = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);

    write_d = 1'b0;
    addr_d  = '0;
    wdata_d = 32'h0;
    if (busy_d) begin
      if (state_q == IDLE) begin
        write_d = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end else begin
        write_d = write;
        addr_d  = addr;
        wdata_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      sel       <= 1'b0;
      enable    <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      sel       <= sel_d;
      enable    <= enable_d;
      write     <= write_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed and randomized transfers against a cycle-count reference of the bus initiator.
module tb_uart_bus_master;
  import uart_bus_pkg::*;

  localparam int TO = 6;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          sel, enable, write;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata = 32'h0;
  logic          ready = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_bus_master #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sel       (sel),
    .enable    (enable),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic s, input logic e, input logic w,
                         input logic [AW-1:0] a, input logic [31:0] d);
    chk1({tag, ".sel"}, sel, s);
    chk1({tag, ".enable"}, enable, e);
    chk1({tag, ".write"}, write, w);
    chk({tag, ".addr"}, 32'(addr), 32'(a));
    chk({tag, ".wdata"}, wdata, d);
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] rd, input logic er);
    chk1({tag, ".rsp_valid"}, rsp_valid, v);
    chk({tag, ".rsp_rdata"}, rsp_rdata, rd);
    chk1({tag, ".rsp_err"}, rsp_err, er);
  endtask

  // Slave inserts w not-ready ACCESS cycles, then ready with rd. Expected outcome comes
  // purely from cycle arithmetic: completion iff ready lands on ACCESS cycle <= TO.
  // Observation j = negedge after the j-th edge following the accept edge.
  task automatic do_xfer(input string nm, input logic wr, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int w,
                         input int bp, input logic spur, input int rst_at);
    logic        ok;
    int          d;
    logic [31:0] er;
    ok = (w < TO);
    d  = ok ? w + 2 : TO + 1;
    er = (ok && !wr) ? rd : 32'h0;

    chk1({nm, ".idle_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    ready     = spur;
    rdata     = $urandom;

    for (int j = 0; j < d; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
      end
      chk_bus($sformatf("%s.bus%0d", nm, j), 1'b1, (j >= 1), wr, a, wd);
      chk1($sformatf("%s.busy_rsp_valid%0d", nm, j), rsp_valid, 1'b0);
      chk1($sformatf("%s.busy_req_ready%0d", nm, j), req_ready, 1'b0);
      if (j == rst_at) begin
        rst = 1'b1;
        ready = 1'b0;
        #1;
        chk_bus({nm, ".rst_bus"}, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        chk_rsp({nm, ".rst_rsp"}, 1'b0, 32'h0, 1'b0);
        chk1({nm, ".rst_req_ready"}, req_ready, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk1({nm, ".rst_hold_valid"}, rsp_valid, 1'b0);
          chk1({nm, ".rst_hold_sel"}, sel, 1'b0);
          chk1({nm, ".rst_hold_req_ready"}, req_ready, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk1({nm, ".post_rst_req_ready"}, req_ready, 1'b1);
        chk1({nm, ".post_rst_valid"}, rsp_valid, 1'b0);
        chk1({nm, ".post_rst_sel"}, sel, 1'b0);
        return;
      end
      if (j == 0) begin
        ready = spur;
        rdata = $urandom;
      end else begin
        ready = (j - 1 == w);
        rdata = (j - 1 == w) ? rd : $urandom;
      end
    end

    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      chk_rsp($sformatf("%s.rsp%0d", nm, k), 1'b1, er, !ok);
      chk_bus($sformatf("%s.rsp_bus%0d", nm, k), 1'b0, 1'b0, 1'b0, '0, 32'h0);
      chk1($sformatf("%s.rsp_req_ready%0d", nm, k), req_ready, 1'b0);
      ready     = spur ? 1'($urandom) : 1'b0;
      rdata     = $urandom;
      req_valid = (bp > 0);
      rsp_ready = (k == bp);
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    chk1({nm, ".done_valid"}, rsp_valid, 1'b0);
    chk1({nm, ".done_req_ready"}, req_ready, 1'b1);
    chk1({nm, ".done_not_accepted"}, sel, 1'b0);
    req_valid = 1'b0;
    ready     = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk_bus("reset_bus", 1'b0, 1'b0, 1'b0, '0, 32'h0);
    chk_rsp("reset_rsp", 1'b0, 32'h0, 1'b0);
    chk1("reset_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("release_req_ready", req_ready, 1'b1);

    do_xfer("wr_zero_wait", 1'b1, REG_BAUD, 32'h0000_01B2, 32'hDEAD_BEEF, 0, 0, 1'b0, -1);
    do_xfer("rd_wait5", 1'b0, REG_TR, 32'h0, 32'h0000_0041, 5, 0, 1'b0, -1);
    do_xfer("timeout", 1'b0, REG_CTRL, 32'h0, 32'h0000_0055, 1000, 0, 1'b0, -1);
    do_xfer("ready_at_limit", 1'b0, REG_CTRL, 32'h0, 32'h0000_0077, TO - 1, 0, 1'b0, -1);
    do_xfer("wr_timeout", 1'b1, REG_TR, 32'h0000_005A, 32'h0000_0077, TO, 0, 1'b0, -1);
    do_xfer("backpressure", 1'b0, REG_BAUD, 32'h0, 32'h0000_1234, 2, 10, 1'b0, -1);
    do_xfer("rst_access", 1'b0, REG_TR, 32'h0, 32'h0000_0099, 1000, 0, 1'b0, 3);
    do_xfer("rd_after_rst", 1'b0, REG_CTRL, 32'h0, 32'h0000_CAFE, 1, 0, 1'b0, -1);
    do_xfer("spurious", 1'b1, REG_TR, 32'h0000_0001, 32'h0, 0, 0, 1'b1, -1);

    for (int i = 0; i < 24; i++) begin
      do_xfer($sformatf("rand%0d", i), 1'($urandom), AW'($urandom), $urandom, $urandom,
              $urandom_range(0, TO + 1), $urandom_range(0, 3), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
